// File: rtl/jtsdram_bank_check_if.sv
// ---------------------------------------------------------------------------
// jtsdram_bank_check_if
// Request/response bus between the bank tester and one SDRAM bank port.
//
//   addr       word address of the current access
//   rd         read request, held until ack
//   wr         write request, held until ack
//   din        write data, valid while wr is high
//   ack        request accepted by the bank port
//   rdy        access complete; data_read is valid for reads
//   data_read  read data returned by the bank port
//
// master: the tester (drives requests); slave: the SDRAM bank port.
// ---------------------------------------------------------------------------
interface jtsdram_bank_check_if #(
  parameter int AW = 22,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] din;
  logic          ack;
  logic          rdy;
  logic [DW-1:0] data_read;

  modport master (
    output addr, rd, wr, din,
    input  ack, rdy, data_read
  );

  modport slave (
    input  addr, rd, wr, din,
    output ack, rdy, data_read
  );
endinterface

// File: rtl/jtsdram_bank_check.sv
// ---------------------------------------------------------------------------
// jtsdram_bank_check
// SDRAM bank tester. After a start pulse it optionally fills the whole bank
// with a selectable 16-bit pattern (replicated across the data width), then
// reads every word back and compares it against the same pattern. Mismatches
// are counted (saturating) and the address of the first one is kept.
//
// Parameters
//   AW     address width in words; the sweep covers 0 .. 2^AW-1
//   DW     data width, a multiple of 16
//   ECW    error counter width
//   WR_EN  1: write phase then read phase; 0: read phase only
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   LVBL       high: new requests may be issued; low: hold off new requests
//   start      one-cycle pulse, (re)starts the test from any state
//   mode       pattern select, sampled at start
//                0 constant seed, 1 address^seed, 2 checkerboard, 3 LFSR
//   seed       pattern seed, sampled at start
//   bus        master side of the bank request/response bus
//   busy       test running
//   done       sweep finished, held until the next start
//   bad        at least one mismatch since start
//   err_cnt    number of mismatching words, saturating at all-ones
//   first_bad  address of the first mismatch, 0 if none
// ---------------------------------------------------------------------------
module jtsdram_bank_check #(
  parameter int AW    = 22,
  parameter int DW    = 32,
  parameter int ECW   = 16,
  parameter bit WR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 LVBL,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [15:0]          seed,
  jtsdram_bank_check_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 bad,
  output logic [ECW-1:0]       err_cnt,
  output logic [AW-1:0]        first_bad
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WREQ  = 3'd1;
  localparam logic [2:0] ST_WWAIT = 3'd2;
  localparam logic [2:0] ST_RREQ  = 3'd3;
  localparam logic [2:0] ST_RWAIT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int REP = DW / 16;

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [2:0]     state_reg,     state_next;
  logic [AW-1:0]  addr_reg,      addr_next;
  logic           rd_reg,        rd_next;
  logic           wr_reg,        wr_next;
  logic [DW-1:0]  din_reg,       din_next;
  logic           busy_reg,      busy_next;
  logic           done_reg,      done_next;
  logic           bad_reg,       bad_next;
  logic [ECW-1:0] err_cnt_reg,   err_cnt_next;
  logic [AW-1:0]  first_bad_reg, first_bad_next;
  logic [1:0]     mode_reg,      mode_next;
  logic [15:0]    seed_reg,      seed_next;
  logic [15:0]    lfsr_reg,      lfsr_next;

  // ------------------------------------------------------------------------
  // Pattern generation
  // ------------------------------------------------------------------------
  logic [15:0]   addr16;
  logic [15:0]   seed_eff;
  logic [15:0]   lfsr_step;
  logic [15:0]   pat16;
  logic [DW-1:0] expect_word;
  logic          addr_last;
  logic          err_sat;
  logic          mismatch;

  // Address-mode pattern uses the low 16 address bits, zero-extended when
  // the bank is smaller than 64k words.
  generate
    if (AW >= 16) begin : g_addr_wide
      assign addr16 = addr_reg[15:0];
    end else begin : g_addr_narrow
      assign addr16 = {{(16-AW){1'b0}}, addr_reg};
    end
  endgenerate

  // An all-zero LFSR would lock up, so seed 0 in LFSR mode becomes 1.
  assign seed_eff = (mode == 2'd3 && seed == 16'd0) ? 16'h0001 : seed;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: shift left, feedback into bit 0.
  assign lfsr_step = {lfsr_reg[14:0],
                      lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  always_comb begin
    pat16 = seed_reg;
    case (mode_reg)
      2'd0:    pat16 = seed_reg;
      2'd1:    pat16 = addr16 ^ seed_reg;
      2'd2:    pat16 = seed_reg ^ {16{addr_reg[0]}};
      default: pat16 = lfsr_reg;
    endcase
  end

  // The 16-bit pattern is replicated across the full data width.
  genvar gi;
  generate
    for (gi = 0; gi < REP; gi++) begin : g_rep
      assign expect_word[gi*16 +: 16] = pat16;
    end
  endgenerate

  assign addr_last = &addr_reg;
  assign err_sat   = &err_cnt_reg;
  assign mismatch  = (bus.data_read != expect_word);

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    rd_next        = rd_reg;
    wr_next        = wr_reg;
    din_next       = din_reg;
    busy_next      = busy_reg;
    done_next      = done_reg;
    bad_next       = bad_reg;
    err_cnt_next   = err_cnt_reg;
    first_bad_next = first_bad_reg;
    mode_next      = mode_reg;
    seed_next      = seed_reg;
    lfsr_next      = lfsr_reg;

    if (start) begin
      // Restart wins over everything; an access in flight is abandoned and
      // any ack/rdy arriving this cycle is ignored.
      addr_next      = '0;
      rd_next        = 1'b0;
      wr_next        = 1'b0;
      busy_next      = 1'b1;
      done_next      = 1'b0;
      bad_next       = 1'b0;
      err_cnt_next   = '0;
      first_bad_next = '0;
      mode_next      = mode;
      seed_next      = seed_eff;
      lfsr_next      = seed_eff;
      state_next     = WR_EN ? ST_WREQ : ST_RREQ;
    end else begin
      case (state_reg)
        ST_WREQ: begin
          // LVBL only gates issuing; it never aborts an access.
          if (LVBL) begin
            wr_next    = 1'b1;
            din_next   = expect_word;
            state_next = ST_WWAIT;
          end
        end

        ST_WWAIT: begin
          if (bus.ack) wr_next = 1'b0;
          // ack and rdy may land together; both are handled here.
          if (bus.rdy) begin
            wr_next = 1'b0;
            if (addr_last) begin
              // Write phase complete: rewind for the read-back pass.
              addr_next  = '0;
              lfsr_next  = seed_reg;
              state_next = ST_RREQ;
            end else begin
              addr_next  = addr_reg + 1'b1;
              lfsr_next  = lfsr_step;
              state_next = ST_WREQ;
            end
          end
        end

        ST_RREQ: begin
          if (LVBL) begin
            rd_next    = 1'b1;
            state_next = ST_RWAIT;
          end
        end

        ST_RWAIT: begin
          if (bus.ack) rd_next = 1'b0;
          if (bus.rdy) begin
            rd_next = 1'b0;
            if (mismatch) begin
              bad_next = 1'b1;
              if (!err_sat) err_cnt_next = err_cnt_reg + 1'b1;
              // Only the very first failing address is kept.
              if (!bad_reg) first_bad_next = addr_reg;
            end
            if (addr_last) begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              state_next = ST_DONE;
            end else begin
              addr_next  = addr_reg + 1'b1;
              lfsr_next  = lfsr_step;
              state_next = ST_RREQ;
            end
          end
        end

        // IDLE and DONE hold every output until the next start.
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      din_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      bad_reg       <= 1'b0;
      err_cnt_reg   <= '0;
      first_bad_reg <= '0;
      mode_reg      <= 2'd0;
      seed_reg      <= 16'd0;
      lfsr_reg      <= 16'd0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      rd_reg        <= rd_next;
      wr_reg        <= wr_next;
      din_reg       <= din_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      bad_reg       <= bad_next;
      err_cnt_reg   <= err_cnt_next;
      first_bad_reg <= first_bad_next;
      mode_reg      <= mode_next;
      seed_reg      <= seed_next;
      lfsr_reg      <= lfsr_next;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.addr  = addr_reg;
  assign bus.rd    = rd_reg;
  assign bus.wr    = wr_reg;
  assign bus.din   = din_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign bad       = bad_reg;
  assign err_cnt   = err_cnt_reg;
  assign first_bad = first_bad_reg;

endmodule

// File: tb/tb_jtsdram_bank_check.sv
// ---------------------------------------------------------------------------
// tb_jtsdram_bank_check
// Two testers share one bank model: dut (write+read) and dut_ro (read only).
// sel picks which tester the bank model serves and the monitor observes.
// Expected writes, read addresses and final status are queued when a sweep
// is started and consumed as the tester produces them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtsdram_bank_check;
  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int ECW = 2;
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_FIN = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           lvbl;
  logic [1:0]     start_a;
  logic [1:0]     mode;
  logic [15:0]    seed;
  logic           sel;
  logic [1:0]     busy_a, done_a, bad_a;
  logic [ECW-1:0] err0, err1;
  logic [AW-1:0]  fb0, fb1;

  jtsdram_bank_check_if #(.AW(AW), .DW(DW)) bus0 ();
  jtsdram_bank_check_if #(.AW(AW), .DW(DW)) bus1 ();

  jtsdram_bank_check #(.AW(AW), .DW(DW), .ECW(ECW), .WR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .LVBL(lvbl), .start(start_a[0]), .mode(mode), .seed(seed),
    .bus(bus0), .busy(busy_a[0]), .done(done_a[0]), .bad(bad_a[0]),
    .err_cnt(err0), .first_bad(fb0)
  );

  jtsdram_bank_check #(.AW(AW), .DW(DW), .ECW(ECW), .WR_EN(1'b0)) dut_ro (
    .clk(clk), .rst_n(rst_n), .LVBL(lvbl), .start(start_a[1]), .mode(mode), .seed(seed),
    .bus(bus1), .busy(busy_a[1]), .done(done_a[1]), .bad(bad_a[1]),
    .err_cnt(err1), .first_bad(fb1)
  );

  // ---------------- bank model ----------------
  logic        ack_r, rdy_r, op_wr;
  logic [1:0]  ph;
  logic [31:0] rdata;
  logic [31:0] mem [16];
  logic [15:0] cmask;
  logic        call;

  logic          m_rd, m_wr, m_busy, m_done, m_bad;
  logic [AW-1:0] m_addr, m_fb;
  logic [31:0]   m_din;
  logic [ECW-1:0] m_err;

  assign m_rd   = sel ? bus1.rd   : bus0.rd;
  assign m_wr   = sel ? bus1.wr   : bus0.wr;
  assign m_addr = sel ? bus1.addr : bus0.addr;
  assign m_din  = sel ? bus1.din  : bus0.din;
  assign m_busy = sel ? busy_a[1] : busy_a[0];
  assign m_done = sel ? done_a[1] : done_a[0];
  assign m_bad  = sel ? bad_a[1]  : bad_a[0];
  assign m_err  = sel ? err1 : err0;
  assign m_fb   = sel ? fb1  : fb0;

  assign bus0.ack = ack_r & ~sel;
  assign bus1.ack = ack_r &  sel;
  assign bus0.rdy = rdy_r & ~sel;
  assign bus1.rdy = rdy_r &  sel;
  assign bus0.data_read = rdata;
  assign bus1.data_read = rdata;

  // Random ack delay; rdy either with ack or one or more cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0; rdy_r <= 1'b0; ph <= 2'd0; op_wr <= 1'b0; rdata <= 32'd0;
    end else begin
      ack_r <= 1'b0;
      rdy_r <= 1'b0;
      case (ph)
        2'd0: if ((m_rd || m_wr) && $urandom_range(0, 3) != 0) begin
          ack_r <= 1'b1;
          op_wr <= m_wr;
          if (m_wr) mem[m_addr] <= m_din;
          else rdata <= mem[m_addr] ^ ((call || cmask[m_addr]) ? 32'h0000_0100 : 32'd0);
          if ($urandom_range(0, 1) == 1) begin rdy_r <= 1'b1; ph <= 2'd2; end
          else ph <= 2'd1;
        end
        2'd1: if ($urandom_range(0, 2) != 0) begin rdy_r <= 1'b1; ph <= 2'd2; end
        default: ph <= 2'd0;
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] pat(input logic [1:0] m, input logic [15:0] s,
                                      input int a, input logic [15:0] l);
    case (m)
      2'd0:    return s;
      2'd1:    return 16'(a) ^ s;
      2'd2:    return (a % 2 == 1) ? ~s : s;
      default: return l;
    endcase
  endfunction

  task automatic push_sweep(input bit wr_en, input logic [1:0] m, input logic [15:0] s,
                            input logic [15:0] cm, input bit ca);
    logic [15:0] s_eff, l, p;
    int errs, fb;
    bit b;
    s_eff = (m == 2'd3 && s == 16'd0) ? 16'h0001 : s;
    errs = 0; fb = 0; b = 1'b0;
    if (wr_en) begin
      l = s_eff;
      for (int a = 0; a < 16; a++) begin
        p = pat(m, s_eff, a, l);
        exp_q.push_back('{kind: K_WR, addr: 4'(a), data: {p, p}});
        l = lfsr_step(l);
      end
    end
    for (int a = 0; a < 16; a++) begin
      exp_q.push_back('{kind: K_RD, addr: 4'(a), data: 32'd0});
      if (ca || cm[a]) begin
        if (!b) fb = a;
        b = 1'b1;
        if (errs < 3) errs++;
      end
    end
    exp_q.push_back('{kind: K_FIN, addr: 4'd0, data: {25'd0, b, 2'(errs), 4'(fb)}});
  endtask

  logic done_q;
  always @(negedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= m_done;
      if (ack_r && op_wr) begin
        $display("WR addr=%0d din=%h", m_addr, m_din);
        if (exp_q.size() == 0) chk("sb_unexpected_wr", 32'd1, 32'd0);
        else begin
          chk("wr_kind", 32'(K_WR), 32'(exp_q[0].kind));
          chk("wr_addr", 32'(m_addr), 32'(exp_q[0].addr));
          chk("wr_data", m_din, exp_q[0].data);
          exp_q.delete(0);
        end
      end
      if (rdy_r && !op_wr) begin
        $display("RD addr=%0d data=%h", m_addr, rdata);
        if (exp_q.size() == 0) chk("sb_unexpected_rd", 32'd1, 32'd0);
        else begin
          chk("rd_kind", 32'(K_RD), 32'(exp_q[0].kind));
          chk("rd_addr", 32'(m_addr), 32'(exp_q[0].addr));
          exp_q.delete(0);
        end
      end
      if (m_done && !done_q) begin
        $display("DONE bad=%0d err_cnt=%0d first_bad=%0d", m_bad, m_err, m_fb);
        if (exp_q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
        else begin
          chk("fin_kind", 32'(K_FIN), 32'(exp_q[0].kind));
          chk("fin_bad", 32'(m_bad), 32'(exp_q[0].data[6]));
          chk("fin_err_cnt", 32'(m_err), 32'(exp_q[0].data[5:4]));
          chk("fin_first_bad", 32'(m_fb), 32'(exp_q[0].data[3:0]));
          exp_q.delete(0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [1:0] m, input logic [15:0] s);
    @(negedge clk);
    mode = m; seed = s;
    start_a[sel] = 1'b1;
    @(negedge clk);
    start_a = 2'b00;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (m_done) break;
      @(negedge clk);
    end
    chk("done_reached", 32'(m_done), 32'd1);
    chk("busy_after_done", 32'(m_busy), 32'd0);
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_sweep(input bit wr_en, input logic [1:0] m, input logic [15:0] s);
    push_sweep(wr_en, m, s, cmask, call);
    pulse_start(m, s);
    wait_done(2000);
  endtask

  initial begin
    rst_n = 1'b0; lvbl = 1'b1; start_a = 2'b00; mode = 2'd0; seed = 16'd0;
    sel = 1'b0; cmask = 16'd0; call = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_rd",        32'(bus0.rd),   32'd0);
    chk("rst_wr",        32'(bus0.wr),   32'd0);
    chk("rst_addr",      32'(bus0.addr), 32'd0);
    chk("rst_din",       bus0.din,       32'd0);
    chk("rst_busy",      32'(busy_a),    32'd0);
    chk("rst_done",      32'(done_a),    32'd0);
    chk("rst_bad",       32'(bad_a),     32'd0);
    chk("rst_err_cnt",   32'(err0),      32'd0);
    chk("rst_first_bad", 32'(fb0),       32'd0);
    chk("rst_ro_rd",     32'(bus1.rd),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant pattern, ideal bank; done must stay asserted while idle.
    run_sweep(1'b1, 2'd0, 16'hA55A);
    repeat (5) @(negedge clk);
    chk("done_hold", 32'(m_done), 32'd1);
    chk("no_req_in_done", 32'(m_rd | m_wr), 32'd0);

    // Address pattern, two corrupted words.
    cmask = 16'h0220;
    run_sweep(1'b1, 2'd1, 16'h0000);
    cmask = 16'd0;

    // Checkerboard, every read wrong: counter saturates.
    call = 1'b1;
    run_sweep(1'b1, 2'd2, 16'h3C3C);
    call = 1'b0;

    // LVBL dropped right as a write is acked.
    push_sweep(1'b1, 2'd0, 16'h1234, 16'd0, 1'b0);
    pulse_start(2'd0, 16'h1234);
    for (int i = 0; i < 500; i++) begin
      if (ack_r && op_wr && m_addr == 4'd4) break;
      @(negedge clk);
    end
    chk("lvbl_sync", 32'(ack_r && op_wr && m_addr == 4'd4), 32'd1);
    lvbl = 1'b0;
    begin
      int reqs;
      reqs = 0;
      repeat (20) begin
        @(negedge clk);
        if (m_rd || m_wr) reqs++;
      end
      chk("lvbl_no_new_req", 32'(reqs), 32'd0);
      chk("lvbl_access_done", 32'(m_addr), 32'd5);
      chk("lvbl_busy", 32'(m_busy), 32'd1);
    end
    lvbl = 1'b1;
    wait_done(2000);

    // Restart while the read of word 7 completes.
    cmask = 16'h000C;
    push_sweep(1'b1, 2'd0, 16'h0F0F, cmask, 1'b0);
    pulse_start(2'd0, 16'h0F0F);
    for (int i = 0; i < 1000; i++) begin
      if (rdy_r && !op_wr && m_addr == 4'd7) break;
      @(negedge clk);
    end
    chk("restart_sync", 32'(rdy_r && !op_wr && m_addr == 4'd7), 32'd1);
    chk("pre_restart_err", 32'(m_err), 32'd2);
    start_a[0] = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    cmask = 16'd0;
    chk("restart_addr",    32'(m_addr), 32'd0);
    chk("restart_err_cnt", 32'(m_err),  32'd0);
    chk("restart_bad",     32'(m_bad),  32'd0);
    chk("restart_fb",      32'(m_fb),   32'd0);
    chk("restart_busy",    32'(m_busy), 32'd1);
    chk("restart_rd",      32'(m_rd),   32'd0);
    push_sweep(1'b1, 2'd0, 16'h0F0F, 16'd0, 1'b0);
    @(negedge clk);
    start_a = 2'b00;
    wait_done(2000);

    // LFSR with seed 0: fill with dut, then read back with the read-only tester.
    run_sweep(1'b1, 2'd3, 16'h0000);
    sel = 1'b1;
    @(negedge clk);
    run_sweep(1'b0, 2'd3, 16'h0000);

    // Reset in the middle of a read.
    push_sweep(1'b0, 2'd3, 16'h0000, 16'd0, 1'b0);
    pulse_start(2'd3, 16'h0000);
    for (int i = 0; i < 200; i++) begin
      if (m_rd && m_addr == 4'd3) break;
      @(negedge clk);
    end
    chk("rst_mid_sync", 32'(m_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_rd",   32'(m_rd),   32'd0);
    chk("rst_mid_addr", 32'(m_addr), 32'd0);
    chk("rst_mid_busy", 32'(m_busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(m_rd | m_busy | m_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
